// File: rtl/bp_gshare_btb.sv
// Branch predictor: direct-mapped BTB with a 2-bit PHT, bimodal or gshare-indexed, 1-cycle lookup.
// Latency 1 cycle; pred_* hold while if_allowin=0, and if_flush drops the held prediction.
module bp_gshare_btb #(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 64,
    parameter int GHR_W   = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                if_valid,
    input  logic [PC_W-1:0]                     if_pc,
    input  logic                                if_allowin,
    input  logic                                if_flush,
    output logic                                pred_valid,
    output logic                                pred_hit,
    output logic                                pred_taken,
    output logic [PC_W-1:0]                     pred_target,
    output logic [((GHR_W > 0) ? GHR_W : 1)-1:0] pred_ghr,
    input  logic                                upd_valid,
    input  logic [PC_W-1:0]                     upd_pc,
    input  logic                                upd_taken,
    input  logic [PC_W-1:0]                     upd_target,
    input  logic                                upd_mispredict,
    input  logic [((GHR_W > 0) ? GHR_W : 1)-1:0] upd_ghr
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int HW    = (GHR_W > 0) ? GHR_W : 1;
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic             btb_vld [ENTRIES];
    logic [TAG_W-1:0] btb_tag [ENTRIES];
    logic [PC_W-1:0]  btb_tgt [ENTRIES];
    logic [1:0]       pht     [ENTRIES];
    logic [HW-1:0]    ghr;

    logic [IDX_W-1:0] l_bidx, l_pidx, u_bidx, u_pidx;
    logic             l_hit, l_taken, accept;
    logic [PC_W-1:0]  l_target;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    always_comb begin
        l_bidx   = if_pc[IDX_W+1:2];
        u_bidx   = upd_pc[IDX_W+1:2];
        l_pidx   = l_bidx;
        u_pidx   = u_bidx;
        if (GHR_W > 0) begin
            l_pidx = l_bidx ^ IDX_W'(ghr);
            u_pidx = u_bidx ^ IDX_W'(upd_ghr);
        end
        l_hit    = btb_vld[l_bidx] && (btb_tag[l_bidx] == if_pc[PC_W-1:IDX_W+2]);
        l_taken  = l_hit && pht[l_pidx][1];
        l_target = l_taken ? btb_tgt[l_bidx] : if_pc + PC_W'(4);
        // A flush on the same edge cancels acceptance, so wrong-path fetches never shift history.
        accept   = if_valid && if_allowin && !if_flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_vld[i] <= 1'b0;
                pht[i]     <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_taken && pht[u_pidx] != 2'b11)
                pht[u_pidx] <= pht[u_pidx] + 2'b01;
            else if (!upd_taken && pht[u_pidx] != 2'b00)
                pht[u_pidx] <= pht[u_pidx] - 2'b01;
            if (upd_taken)
                btb_vld[u_bidx] <= 1'b1;
        end
    end

    // Tag and target are qualified by btb_vld, so they need no reset.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag[u_bidx] <= upd_pc[PC_W-1:IDX_W+2];
            btb_tgt[u_bidx] <= upd_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ghr <= '0;
        else if (GHR_W == 0)
            ghr <= '0;
        else if (upd_valid && upd_mispredict)
            ghr <= (upd_ghr << 1) | HW'(upd_taken);
        else if (accept && l_hit)
            ghr <= (ghr << 1) | HW'(l_taken);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            pred_ghr    <= '0;
        end else if (if_flush) begin
            pred_valid <= 1'b0;
        end else if (if_allowin) begin
            if (if_valid) begin
                pred_valid  <= 1'b1;
                pred_hit    <= l_hit;
                pred_taken  <= l_taken;
                pred_target <= l_target;
                pred_ghr    <= (GHR_W > 0) ? ghr : '0;
            end else begin
                pred_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/bp_gshare_btb.md
BP_GSHARE_BTB -- requirements
Module: bp_gshare_btb

Interface
REQ-001 SHALL have parameter PC_W, 32, PC and target width.
REQ-002 SHALL have parameter ENTRIES, 64, BTB/PHT entry count, power of two, 4..1024; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter GHR_W, 0, global history bits; 0 = bimodal, 1..IDX_W = gshare.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port if_valid, input, 1, fetch lookup request.
REQ-007 SHALL have port if_pc, input, PC_W, fetch PC.
REQ-008 SHALL have port if_allowin, input, 1, fetch accepts a new prediction.
REQ-009 SHALL have port if_flush, input, 1, discard the held prediction.
REQ-010 SHALL have ports pred_valid (1), pred_hit (1), pred_taken (1), pred_target (PC_W) and pred_ghr (max(GHR_W,1)), all outputs, all registered prediction results.
REQ-011 SHALL have ports upd_valid (1), upd_pc (PC_W), upd_taken (1), upd_target (PC_W), upd_mispredict (1) and upd_ghr (max(GHR_W,1)), all inputs, issue-stage resolution.

Function
REQ-012 SHALL hold per entry: BTB valid, tag = pc[PC_W-1:IDX_W+2], target; PHT 2-bit saturating counter.
REQ-013 SHALL index BTB by pc[IDX_W+1:2]; PHT by pc[IDX_W+1:2] XOR zero-extended GHR, or pc bits only when GHR_W=0.
REQ-014 SHALL define a lookup as accepted at an edge where if_valid & if_allowin; result SHALL appear on outputs after that edge (1-cycle latency).
REQ-015 SHALL set hit = BTB valid & tag match; taken = hit & counter[1]; target = taken ? BTB target : if_pc+4 (mod 2^PC_W).
REQ-016 SHALL capture hit/taken/target, the GHR used and pred_valid=1 on acceptance.
REQ-017 SHALL hold all pred_* while if_allowin=0; SHALL clear pred_valid on an edge with if_allowin=1 and no request.
REQ-018 SHALL clear pred_valid on if_flush; if_flush SHALL take priority over a same-edge acceptance.
REQ-019 SHALL, on upd_valid, saturating-increment the PHT counter if upd_taken, else saturating-decrement (limits 3 and 0).
REQ-020 SHALL, on upd_valid & upd_taken, write valid=1, tag and upd_target into the BTB entry, overwriting on tag mismatch; not-taken updates SHALL NOT allocate or invalidate.
REQ-021 SHALL compute the update PHT index from upd_pc XOR upd_ghr.
REQ-022 SHALL, when GHR_W>0, shift the GHR left on an accepted lookup with hit, inserting predicted taken.
REQ-023 SHALL, on upd_valid & upd_mispredict, load GHR = {upd_ghr[GHR_W-2:0], upd_taken}; this SHALL override a same-edge lookup shift.
REQ-024 SHALL make a same-edge lookup and update to the same index see pre-update table contents (read-before-write).
REQ-025 SHALL drive pred_ghr to 0 and keep GHR constant 0 when GHR_W=0.

Reset
REQ-026 SHALL, on reset, asynchronously clear all BTB valid bits, set all counters to 2'b01, clear the GHR, and drive pred_valid, pred_hit, pred_taken, pred_target and pred_ghr to 0.
REQ-027 SHALL discard an in-flight lookup when reset asserts mid-operation, and SHALL give no prediction until the first accepted lookup after release.

Verification
REQ-028 Bimodal miss: ENTRIES=64, GHR_W=0; after reset, lookup 0x1c000010 -> next cycle pred_valid=1, hit=0, taken=0, target=0x1c000014.
REQ-029 Train: one update at 0x1c000010 with taken=1 and target 0x1c000100; lookup -> hit=1, counter=2, taken=1, target=0x1c000100; three not-taken updates -> counter=0 and taken=0; a fourth -> counter stays 0.
REQ-030 Alias: train taken at 0x1c000010 and lookup 0x1c000110 (same index, different tag) -> hit=0, target=0x1c000114.
REQ-031 Stall and flush: if_allowin=0 for 3 cycles -> outputs stable; if_flush with a concurrent request -> pred_valid=0.
REQ-032 Gshare: GHR_W=4; three hit lookups predicted taken -> GHR=4'b0111; mispredict update with upd_ghr=4'b0011 and taken=0 -> GHR=4'b0110, overriding a same-edge lookup.
REQ-033 Reset mid-run: assert reset after training -> all pred_* = 0 immediately; post-release lookup at the trained PC -> hit=0.
